// File: rtl/sp1_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, req/ack start
// handshake, result and divide-by-zero flag held valid until the next accepted request.
module sp1_divider #(
    parameter int unsigned DW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req,
    output logic          o_ack,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_q,
    output logic [DW-1:0] o_r,
    output logic          o_valid,
    output logic          o_dz
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t        r_state, w_state_nx;
    logic          r_ack, w_ack_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [DW:0]   r_rem, w_rem_nx;
    logic [DW-1:0] r_dvd, w_dvd_nx;
    logic [DW-1:0] r_dvs, w_dvs_nx;
    logic [DW-1:0] r_quo, w_quo_nx;
    logic [DW-1:0] r_q, w_q_nx;
    logic [DW-1:0] r_r, w_r_nx;
    logic          r_valid, w_valid_nx;
    logic          r_dz, w_dz_nx;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [DW:0]   w_rem_sh;
    logic          w_fits;
    logic [DW:0]   w_rem_step;
    logic [DW-1:0] w_quo_step;

    always_comb begin
        w_rem_sh   = {r_rem[DW-1:0], r_dvd[DW-1]};
        w_fits     = (w_rem_sh >= {1'b0, r_dvs});
        w_rem_step = w_fits ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh;
        w_quo_step = {r_quo[DW-2:0], w_fits};
    end

    always_comb begin
        w_state_nx = r_state;
        w_ack_nx   = r_ack;
        w_cnt_nx   = r_cnt;
        w_rem_nx   = r_rem;
        w_dvd_nx   = r_dvd;
        w_dvs_nx   = r_dvs;
        w_quo_nx   = r_quo;
        w_q_nx     = r_q;
        w_r_nx     = r_r;
        w_valid_nx = r_valid;
        w_dz_nx    = r_dz;

        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    w_valid_nx = 1'b0;
                    w_dz_nx    = 1'b0;
                    if (i_b == '0) begin
                        // Divide by zero resolves in the accept edge without entering CALC.
                        w_q_nx     = '1;
                        w_r_nx     = i_a;
                        w_dz_nx    = 1'b1;
                        w_valid_nx = 1'b1;
                    end else begin
                        w_state_nx = S_CALC;
                        w_ack_nx   = 1'b0;
                        w_cnt_nx   = CW'(DW - 1);
                        w_rem_nx   = '0;
                        w_dvd_nx   = i_a;
                        w_dvs_nx   = i_b;
                        w_quo_nx   = '0;
                    end
                end
            end
            S_CALC: begin
                w_rem_nx = w_rem_step;
                w_dvd_nx = {r_dvd[DW-2:0], 1'b0};
                w_quo_nx = w_quo_step;
                w_cnt_nx = r_cnt - CW'(1);
                if (r_cnt == '0) begin
                    w_q_nx     = w_quo_step;
                    w_r_nx     = w_rem_step[DW-1:0];
                    w_valid_nx = 1'b1;
                    w_ack_nx   = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_ack_nx   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b1;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_quo   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_valid <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ack   <= w_ack_nx;
            r_cnt   <= w_cnt_nx;
            r_rem   <= w_rem_nx;
            r_dvd   <= w_dvd_nx;
            r_dvs   <= w_dvs_nx;
            r_quo   <= w_quo_nx;
            r_q     <= w_q_nx;
            r_r     <= w_r_nx;
            r_valid <= w_valid_nx;
            r_dz    <= w_dz_nx;
        end
    end

    assign o_ack   = r_ack;
    assign o_q     = r_q;
    assign o_r     = r_r;
    assign o_valid = r_valid;
    assign o_dz    = r_dz;

endmodule

// File: tb/tb_sp1_divider.sv
// Directed bench for sp1_divider: DW=8 instance for exact timing/handshake vectors,
// DW=16 instance for back-to-back operation with req held high.
module tb_sp1_divider;

    logic        clk;
    logic        rst8, rst16;
    logic        req8, req16;
    logic        ack8, ack16;
    logic [7:0]  a8, b8, q8, r8;
    logic [15:0] a16, b16, q16, r16;
    logic        valid8, valid16, dz8, dz16;

    int n_chk  = 0;
    int n_pass = 0;

    sp1_divider #(.DW(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst8), .i_req(req8), .o_ack(ack8),
        .i_a(a8), .i_b(b8), .o_q(q8), .o_r(r8), .o_valid(valid8), .o_dz(dz8)
    );

    sp1_divider #(.DW(16)) u_dut16 (
        .i_clk(clk), .i_rst(rst16), .i_req(req16), .o_ack(ack16),
        .i_a(a16), .i_b(b16), .o_q(q16), .o_r(r16), .o_valid(valid16), .o_dz(dz16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive one request at a negedge; returns at the negedge after the accept edge.
    task automatic go8(input logic [7:0] a, input logic [7:0] b);
        a8   = a;
        b8   = b;
        req8 = 1'b1;
        @(negedge clk);
        req8 = 1'b0;
    endtask

    // Called right after go8: result must appear exactly 8 edges after accept.
    task automatic res8(input string tag, input logic [7:0] eq, input logic [7:0] er);
        chk({tag, "_ack_lo"}, 32'(ack8), 32'd0);
        repeat (7) @(negedge clk);
        chk({tag, "_early"}, 32'(valid8), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(valid8), 32'd1);
        chk({tag, "_ack"},   32'(ack8),   32'd1);
        chk({tag, "_dz"},    32'(dz8),    32'd0);
        chk({tag, "_q"},     32'(q8),     32'(eq));
        chk({tag, "_r"},     32'(r8),     32'(er));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] a, b, q, r;
    } vec8_t;

    initial begin : main
        vec8_t       v8[3];
        logic [15:0] va[10];
        logic [15:0] vb[10];
        logic [31:0] recon;

        rst8 = 1'b1; rst16 = 1'b1;
        req8 = 1'b0; req16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (5) @(negedge clk);
        rst8 = 1'b0; rst16 = 1'b0;

        // Reset state
        chk("rst_ack",   32'(ack8),    32'd1);
        chk("rst_valid", 32'(valid8),  32'd0);
        chk("rst_q",     32'(q8),      32'd0);
        chk("rst_r",     32'(r8),      32'd0);
        chk("rst_dz",    32'(dz8),     32'd0);
        chk("rst16_ack", 32'(ack16),   32'd1);
        chk("rst16_val", 32'(valid16), 32'd0);

        // Basic 100/7 = 14 rem 2
        go8(8'd100, 8'd7);
        res8("t1", 8'h0E, 8'h02);

        // Boundary vectors
        v8[0] = '{8'd255, 8'd1,   8'hFF, 8'h00};
        v8[1] = '{8'd255, 8'd255, 8'h01, 8'h00};
        v8[2] = '{8'd3,   8'd200, 8'h00, 8'h03};
        foreach (v8[i]) begin
            go8(v8[i].a, v8[i].b);
            res8($sformatf("t2_%0d", i), v8[i].q, v8[i].r);
        end

        // Divide by zero: one-edge latency, ack stays high
        go8(8'd5, 8'd0);
        chk("dz_valid", 32'(valid8), 32'd1);
        chk("dz_flag",  32'(dz8),    32'd1);
        chk("dz_q",     32'(q8),     32'hFF);
        chk("dz_r",     32'(r8),     32'h05);
        chk("dz_ack",   32'(ack8),   32'd1);
        go8(8'd5, 8'd3);
        chk("dz_clr_valid", 32'(valid8), 32'd0);
        chk("dz_clr_dz",    32'(dz8),    32'd0);
        repeat (7) @(negedge clk);
        @(negedge clk);
        chk("dz_next_q", 32'(q8), 32'h01);
        chk("dz_next_r", 32'(r8), 32'h02);

        // Ignored req and operand changes during CALC; req at completion edge deferred
        go8(8'd100, 8'd7);
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd3; req8 = 1'b1;
        @(negedge clk);
        req8 = 1'b0;
        chk("ign_ack",   32'(ack8),   32'd0);
        chk("ign_valid", 32'(valid8), 32'd0);
        repeat (5) @(negedge clk);
        a8 = 8'd50; b8 = 8'd5; req8 = 1'b1;
        @(negedge clk);
        chk("ign_q",      32'(q8),     32'h0E);
        chk("ign_r",      32'(r8),     32'h02);
        chk("ign_valid2", 32'(valid8), 32'd1);
        chk("late_ack",   32'(ack8),   32'd1);
        @(negedge clk);
        req8 = 1'b0;
        chk("late_acc_ack",   32'(ack8),   32'd0);
        chk("late_acc_valid", 32'(valid8), 32'd0);
        repeat (7) @(negedge clk);
        chk("late_early", 32'(valid8), 32'd0);
        @(negedge clk);
        chk("late_valid", 32'(valid8), 32'd1);
        chk("late_q",     32'(q8),     32'h0A);
        chk("late_r",     32'(r8),     32'h00);

        // Reset on the 4th CALC edge aborts the operation
        go8(8'd200, 8'd9);
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("abort_ack",   32'(ack8),   32'd1);
        chk("abort_valid", 32'(valid8), 32'd0);
        chk("abort_q",     32'(q8),     32'd0);
        chk("abort_r",     32'(r8),     32'd0);
        go8(8'd50, 8'd5);
        res8("t5", 8'h0A, 8'h00);

        // DW=16 back-to-back with req held high
        va[0] = 16'h0000; vb[0] = 16'h0000;
        va[1] = 16'hFFFF; vb[1] = 16'h0001;
        va[2] = 16'hFFFF; vb[2] = 16'hFFFF;
        va[3] = 16'h0000; vb[3] = 16'h0005;
        for (int i = 4; i < 10; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom_range(65535, 1));
        end
        req16 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a16 = va[i];
            b16 = vb[i];
            @(negedge clk);
            if (vb[i] == 16'h0) begin
                chk($sformatf("w%0d_dz", i),    32'(dz16),    32'd1);
                chk($sformatf("w%0d_valid", i), 32'(valid16), 32'd1);
                chk($sformatf("w%0d_q", i),     32'(q16),     32'hFFFF);
                chk($sformatf("w%0d_r", i),     32'(r16),     32'(va[i]));
                chk($sformatf("w%0d_ack", i),   32'(ack16),   32'd1);
            end else begin
                chk($sformatf("w%0d_acc", i), 32'(ack16), 32'd0);
                a16 = ~va[i];
                b16 = 16'h0;
                repeat (15) @(negedge clk);
                chk($sformatf("w%0d_early", i), 32'(valid16), 32'd0);
                chk($sformatf("w%0d_busy", i),  32'(ack16),   32'd0);
                @(negedge clk);
                chk($sformatf("w%0d_valid", i), 32'(valid16), 32'd1);
                chk($sformatf("w%0d_ack", i),   32'(ack16),   32'd1);
                chk($sformatf("w%0d_dz", i),    32'(dz16),    32'd0);
                recon = 32'(q16) * 32'(vb[i]) + 32'(r16);
                chk($sformatf("w%0d_inv", i),   recon,        32'(va[i]));
                chk($sformatf("w%0d_rltb", i),  32'(r16 < vb[i]), 32'd1);
                chk($sformatf("w%0d_q", i),     32'(q16),     32'(va[i] / vb[i]));
            end
        end
        req16 = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sp1_divider.md
Name: sp1_divider

Overview:
Multi-cycle unsigned restoring divider for the sp1 ope library. It is the inverse-direction counterpart to the combinational sp1_adder/sp1_incr/sp1_decr set: it repeatedly performs compare-and-subtract instead of adding. It produces one quotient bit per clock and uses a req/ack start handshake and a held valid result. Datapath clients use it where a single-cycle divide is too costly.

Parameters:
DW, 16, operand/result width in bits (min 2).

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset; synchronous and active-high.
req  in  1  start request; sampled at posedge.
ack  out 1  block idle; a req seen while ack=1 is accepted at that edge.
a    in  DW  dividend (unsigned).
b    in  DW  divisor (unsigned).
q    out DW  quotient.
r    out DW  remainder.
valid out 1  q/r/dz hold the result of the last accepted operation.
dz   out 1  divide-by-zero flag for the last operation.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; ack=1; q=0; r=0; valid=0; dz=0.
  - rst has priority over everything, including an in-flight operation. The operation is aborted with no partial result.
- States: IDLE, CALC.
- IDLE:
  - ack=1.
  - On a posedge with req=1, the request is accepted: a and b are captured, and valid and dz are cleared.
  - If b!=0: go to CALC with bit counter=DW-1, partial remainder=0 (DW+1 bits), working dividend=a.
  - If b==0: stay in IDLE. After the same edge: q=all ones, r=a, dz=1, valid=1 (latency 1 edge).
- CALC:
  - ack=0.
  - Each edge: remainder = {remainder[DW-1:0], dividend MSB}; dividend shifts left.
  - If remainder >= divisor: subtract the divisor and shift a 1 into the quotient; else shift in 0.
  - The counter decrements each edge.
  - On the edge where the counter=0: write final q and r, set valid=1, return to IDLE.
- Latency:
  - Request accepted at edge N (b!=0) -> valid=1 and ack=1 visible after edge N+DW.
  - Throughput is one operation per DW+1 edges back-to-back.
- req while ack=0 is ignored and never queued. a/b changes during CALC have no effect.
- valid and q/r/dz hold until the next accepted req or reset. An accepted req drops valid at the accept edge.
- req asserted on the same edge that CALC completes is not accepted (ack=0 at that edge). It is accepted on the next edge if still high.
- Arithmetic:
  - Unsigned only.
  - The remainder register is DW+1 bits so the compare never overflows at the maximum operand values.
  - Invariant when dz=0: a == q*b + r and r < b.
- No X on outputs after the first reset edge. Outputs before the first reset are don't-care.

Test Plan:
1. DW=8, rst for 5 cycles, then req with a=100, b=7 -> ack drops after the accept edge; after 8 more edges valid=1, q=0x0E, r=0x02, dz=0, ack=1.
2. DW=8: a=255, b=1 -> q=0xFF, r=0x00. Then a=255, b=255 -> q=0x01, r=0x00. Then a=3, b=200 -> q=0x00, r=0x03. Each with valid at accept+8.
3. DW=8: a=5, b=0 -> one edge after accept: valid=1, dz=1, q=0xFF, r=0x05, ack stays 1. The next req with b=3 clears dz and valid at its accept edge.
4. DW=8: start 100/7, then pulse req with a=9, b=3 during CALC, and change a/b mid-operation -> the pulse is ignored and the result is still q=0x0E, r=0x02.
5. DW=8: start 200/9; assert rst on the 4th CALC edge -> after that edge ack=1, valid=0, q=0, r=0. A new req 50/5 then gives q=0x0A, r=0x00 at accept+8.
6. DW=16: randomized back-to-back ops with req held high plus 0/0 and 0xFFFF/0x0001 corners -> each result satisfies a==q*b+r with r<b (dz=0 cases). Accepts occur exactly every 17 edges.
